fnd_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller. It generalises the fixed 6-digit display driver:
- configurable digit count and scan rate
- integrated BCD-to-glyph decode
- leading-zero suppression
- per-digit blink
- brightness PWM and inter-digit dead time
- frame-synchronous display update

It sits between the counter/clock datapath and the board FND pins.

---
 rtl/fnd_pkg.sv | 19 +
 rtl/fnd_glyph_dec.sv | 24 ++
 rtl/fnd_scan_ctrl.sv | 114 +++++++++++
 tb/tb_fnd_scan_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared glyph codes, segment bit order and on-window helper
package fnd_pkg;
  typedef enum int {SEG_G_BIT, SEG_F_BIT, SEG_E_BIT, SEG_D_BIT, SEG_C_BIT, SEG_B_BIT, SEG_A_BIT} seg_bit_e;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  function automatic logic [31:0] seg_on_len(input int scan_div, input int dead_cyc, input logic [3:0] bright);
    return (32'(scan_div - dead_cyc) * (32'(bright) + 32'd1)) >> 4;
  endfunction
endpackage

// File: rtl/fnd_glyph_dec.sv
// fnd_glyph_dec: BCD to {a..g} glyph decode, 10 = dash, 11..15 blank
module fnd_glyph_dec
  import fnd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      4'd10:   o_seg = SEG_DASH;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed seven-segment scanner with LZ blanking, blink, PWM and frame-synced update
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int N_DIGIT     = 6,
  parameter int SCAN_DIV    = 5000,
  parameter int DEAD_CYC    = 16,
  parameter int BLINK_DIV   = 25000000,
  parameter bit ENB_ACT_LOW = 1
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*N_DIGIT-1:0] i_digit_bcd,
  input  logic [N_DIGIT-1:0]   i_dp,
  input  logic [N_DIGIT-1:0]   i_blink,
  input  logic                 i_lz_en,
  input  logic [3:0]           i_bright,
  input  logic                 i_upd,
  output logic [6:0]           o_seg,
  output logic                 o_seg_dp,
  output logic [N_DIGIT-1:0]   o_seg_enb,
  output logic                 o_frame
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = N_DIGIT > 1 ? $clog2(N_DIGIT) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(N_DIGIT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [31:0]   DEAD       = 32'(DEAD_CYC);
  logic [SW-1:0]        r_slot_cnt, r_on_len;
  logic [DW-1:0]        r_dig_idx;
  logic [BW-1:0]        r_blink_cnt;
  logic                 r_blink_ph;
  logic [4*N_DIGIT-1:0] r_stg_bcd, r_sh_bcd;
  logic [N_DIGIT-1:0]   r_stg_dp, r_sh_dp, r_stg_blink, r_sh_blink;
  logic                 r_stg_lz, r_sh_lz, r_pend;
  logic [6:0]           r_seg;
  logic                 r_seg_dp, r_frame;
  logic [N_DIGIT-1:0]   r_enb;
  logic                 w_slot_wrap, w_frame_end, w_run, w_sup, w_vis, w_on;
  logic [SW-1:0]        w_on_len;
  logic [N_DIGIT-1:0]   w_lz_sup;
  logic [3:0]           w_bcd;
  logic [6:0]           w_glyph;
  assign w_slot_wrap = r_slot_cnt == SLOT_LAST;
  assign w_frame_end = w_slot_wrap && r_dig_idx == DIG_LAST;
  // brightness is only sampled at slot start so the on-window never jitters mid-slot
  assign w_on_len = r_slot_cnt == '0 ? SW'(seg_on_len(SCAN_DIV, DEAD_CYC, i_bright)) : r_on_len;
  always_comb begin
    w_lz_sup = '0;
    w_run = r_sh_lz;
    for (int k = N_DIGIT - 1; k > 0; k--) begin
      w_run = w_run && r_sh_bcd[4*k +: 4] == 4'd0;
      w_lz_sup[k] = w_run;
    end
  end
  assign w_bcd = r_sh_bcd[4*r_dig_idx +: 4];
  assign w_sup = w_lz_sup[r_dig_idx];
  assign w_vis = !(r_blink_ph && r_sh_blink[r_dig_idx]) && (!w_sup || r_sh_dp[r_dig_idx]);
  assign w_on  = w_vis && 32'(r_slot_cnt) >= DEAD && 32'(r_slot_cnt) < DEAD + 32'(w_on_len);
  fnd_glyph_dec u_dec (.i_bcd(w_bcd), .o_seg(w_glyph));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt  <= '0;
      r_on_len    <= '0;
      r_dig_idx   <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else begin
      r_slot_cnt  <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
      r_on_len    <= w_on_len;
      if (w_slot_wrap) r_dig_idx <= r_dig_idx == DIG_LAST ? '0 : r_dig_idx + 1'b1;
      r_blink_cnt <= r_blink_cnt == BLINK_LAST ? '0 : r_blink_cnt + 1'b1;
      if (r_blink_cnt == BLINK_LAST) r_blink_ph <= !r_blink_ph;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_stg_bcd, r_stg_dp, r_stg_blink, r_stg_lz} <= '0;
      {r_sh_bcd, r_sh_dp, r_sh_blink, r_sh_lz}     <= '0;
      r_pend <= 1'b0;
    end else begin
      if (i_upd) begin
        {r_stg_bcd, r_stg_dp, r_stg_blink, r_stg_lz} <= {i_digit_bcd, i_dp, i_blink, i_lz_en};
        r_pend <= 1'b1;
      end
      // a strobe landing on the boundary bypasses staging so it still makes the next frame
      if (w_frame_end) begin
        if (r_pend || i_upd)
          {r_sh_bcd, r_sh_dp, r_sh_blink, r_sh_lz} <= i_upd ? {i_digit_bcd, i_dp, i_blink, i_lz_en}
                                                            : {r_stg_bcd, r_stg_dp, r_stg_blink, r_stg_lz};
        r_pend <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg    <= '0;
      r_seg_dp <= 1'b0;
      r_enb    <= '0;
      r_frame  <= 1'b0;
    end else begin
      r_seg    <= w_on && !w_sup ? w_glyph : '0;
      r_seg_dp <= w_on && r_sh_dp[r_dig_idx];
      r_enb    <= w_on ? N_DIGIT'(1) << r_dig_idx : '0;
      r_frame  <= r_slot_cnt == '0 && r_dig_idx == '0;
    end
  end
  assign o_seg     = r_seg;
  assign o_seg_dp  = r_seg_dp;
  assign o_seg_enb = ENB_ACT_LOW ? ~r_enb : r_enb;
  assign o_frame   = r_frame;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: randomized scoreboard bench against a positional reference model
module tb_fnd_scan_ctrl;
  localparam int N = 4, S = 40, D = 4, BL = 400, FR = N * S;
  logic clk = 0, rst = 1;
  logic [15:0] i_digit_bcd = '0;
  logic [3:0] i_dp = '0, i_blink = '0, i_bright = 4'd15;
  logic i_lz_en = 0, i_upd = 0;
  logic [6:0] o_seg;
  logic o_seg_dp, o_frame;
  logic [3:0] o_seg_enb;
  typedef struct packed {logic [6:0] seg; logic dp; logic [3:0] enb; logic frame;} out_t;
  out_t q[$];
  int tests = 0, fails = 0;
  logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                             7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b0000001,
                             7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
  always #5 clk = ~clk;
  fnd_scan_ctrl #(.N_DIGIT(N), .SCAN_DIV(S), .DEAD_CYC(D), .BLINK_DIV(BL), .ENB_ACT_LOW(1)) dut (
    .clk(clk), .rst(rst), .i_digit_bcd(i_digit_bcd), .i_dp(i_dp), .i_blink(i_blink),
    .i_lz_en(i_lz_en), .i_bright(i_bright), .i_upd(i_upd), .o_seg(o_seg), .o_seg_dp(o_seg_dp),
    .o_seg_enb(o_seg_enb), .o_frame(o_frame));
  // reference: position n since reset maps directly to digit/slot/blink phase
  initial begin
    int n, cur_on, p, d, s;
    logic [15:0] sh_bcd, st_bcd;
    logic [3:0] sh_dp, st_dp, sh_bl, st_bl;
    logic sh_lz, st_lz, sup, vis, on;
    out_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0; cur_on = 0;
        sh_bcd = 0; st_bcd = 0; sh_dp = 0; st_dp = 0; sh_bl = 0; st_bl = 0; sh_lz = 0; st_lz = 0;
        q.delete();
      end else begin
        p = n % FR; d = p / S; s = p % S;
        if (s == 0) cur_on = ((S - D) * (int'(i_bright) + 1)) / 16;
        sup = sh_lz && d != 0;
        for (int j = d; j < N; j++) if (sh_bcd[4*j +: 4] != 0) sup = 0;
        vis = !(((n / BL) % 2 == 1) && sh_bl[d]) && (!sup || sh_dp[d]);
        on = vis && s >= D && s < D + cur_on;
        e.seg = (on && !sup) ? glyph[sh_bcd[4*d +: 4]] : 7'd0;
        e.dp = on && sh_dp[d];
        e.enb = on ? ~(4'b1 << d) : 4'hF;
        e.frame = p == 0;
        q.push_back(e);
        if (i_upd) begin st_bcd = i_digit_bcd; st_dp = i_dp; st_bl = i_blink; st_lz = i_lz_en; end
        if (p == FR - 1) begin sh_bcd = st_bcd; sh_dp = st_dp; sh_bl = st_bl; sh_lz = st_lz; end
        n++;
      end
    end
  end
  initial begin
    out_t e, g;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        g = {o_seg, o_seg_dp, o_seg_enb, o_frame};
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL out t=%0t got seg=%b dp=%b enb=%b frame=%b exp seg=%b dp=%b enb=%b frame=%b",
                   $time, g.seg, g.dp, g.enb, g.frame, e.seg, e.dp, e.enb, e.frame);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic upd(input logic [15:0] b, input logic [3:0] dp, input logic [3:0] bl, input logic lz);
    @(negedge clk);
    i_digit_bcd = b; i_dp = dp; i_blink = bl; i_lz_en = lz; i_upd = 1;
    @(negedge clk);
    i_upd = 0;
  endtask
  task automatic wait_frame();
    int i;
    i = 0;
    while (o_frame !== 1'b1 && i < 2 * FR) begin @(negedge clk); i++; end
    chk("wait_frame", 32'(o_frame), 1);
  endtask
  initial begin
    int i;
    cyc(3);
    chk("rst_seg", 32'(o_seg), 0);
    chk("rst_dp", 32'(o_seg_dp), 0);
    chk("rst_enb", 32'(o_seg_enb), 4'hF);
    chk("rst_frame", 32'(o_frame), 0);
    rst = 0;
    upd(16'h4321, 4'b0100, 4'b0000, 0);
    cyc(2 * FR);
    i = 0;
    while (o_seg_enb !== 4'b1011 && i < 2 * FR) begin @(negedge clk); i++; end
    chk("wait_dig2", 32'(o_seg_enb), 4'b1011);
    #2 rst = 1;
    #1;
    chk("midrst_enb", 32'(o_seg_enb), 4'hF);
    chk("midrst_seg", 32'(o_seg), 0);
    chk("midrst_dp", 32'(o_seg_dp), 0);
    cyc(3);
    rst = 0;
    cyc(FR);
    upd(16'h4321, 4'b0100, 4'b0000, 0);
    cyc(2 * FR);
    upd(16'h0007, 4'b0000, 4'b0000, 1);
    cyc(2 * FR);
    upd(16'h0000, 4'b0000, 4'b0000, 1);
    cyc(2 * FR);
    upd(16'h0000, 4'b0100, 4'b0000, 1);
    cyc(2 * FR);
    upd(16'h4321, 4'b0000, 4'b0000, 0);
    i_bright = 4'd7;
    cyc(2 * FR);
    i_bright = 4'd0;
    cyc(2 * FR);
    i_bright = 4'd15;
    upd(16'h4321, 4'b0000, 4'b0010, 0);
    cyc(1000);
    wait_frame();
    cyc(50);
    upd(16'h9876, 4'b0001, 4'b0000, 0);
    cyc(FR);
    upd(16'h5555, 4'b0000, 4'b0000, 0);
    cyc(10);
    upd(16'hA0B1, 4'b1000, 4'b0000, 0);
    cyc(2 * FR);
    wait_frame();
    cyc(FR - 2);
    i_digit_bcd = 16'h1234; i_dp = 4'b0010; i_blink = 0; i_lz_en = 0; i_upd = 1;
    @(negedge clk);
    i_upd = 0;
    cyc(2 * FR);
    for (int k = 0; k < 40; k++) begin
      cyc($urandom_range(1, 120));
      if ($urandom_range(0, 3) == 0) i_bright = 4'($urandom);
      else upd(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom), 1'($urandom));
    end
    cyc(2 * FR);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
